// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: NUM_IN producer channels in, one registered consumer channel out.
// in_last exists only when RR_MUX_ARB_HOLD_EN is defined.
interface rr_mux_if #(
  parameter int n      = 16,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*n-1:0] in_data;
  logic [NUM_IN-1:0]   in_valid;
  logic [NUM_IN-1:0]   in_ready;
`ifdef RR_MUX_ARB_HOLD_EN
  logic [NUM_IN-1:0]   in_last;
`endif
  logic [n-1:0]        out_data;
  logic                out_valid;
  logic                out_ready;
  logic [SEL_W-1:0]    out_sel;

  modport slave (
    input  in_data, in_valid,
`ifdef RR_MUX_ARB_HOLD_EN
    input  in_last,
`endif
    input  out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  modport master (
    output in_data, in_valid,
`ifdef RR_MUX_ARB_HOLD_EN
    output in_last,
`endif
    output out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/rr_mux.sv
// Round-robin N:1 registered mux, 1-cycle latency, 1 beat/cycle; all in_ready drop while out_valid && !out_ready.
// RR_MUX_ARB_HOLD_EN: grant stays on one channel until its in_last beat is accepted.
module rr_mux #(
  parameter  int n      = 16,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input logic      clk,
  input logic      rst_n,
  rr_mux_if.slave  bus
);
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] nxt_ptr;
  logic [SEL_W-1:0] rr_win;
  logic [SEL_W-1:0] win;
  logic             rr_any;
  logic             any;
  logic             adv;
  logic             can_load;
  logic             accept;
  logic [n-1:0]     chan [NUM_IN];

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      chan[i] = bus.in_data[i*n +: n];
    end
  end

  // Search from ptr upward with explicit wrap so non-power-of-two NUM_IN works.
  always_comb begin
    int tmp;
    logic [SEL_W-1:0] idx;
    tmp    = 0;
    idx    = '0;
    rr_win = '0;
    rr_any = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      tmp = int'(ptr) + k;
      if (tmp >= NUM_IN) tmp = tmp - NUM_IN;
      idx = SEL_W'(tmp);
      if (!rr_any && bus.in_valid[idx]) begin
        rr_any = 1'b1;
        rr_win = idx;
      end
    end
  end

`ifdef RR_MUX_ARB_HOLD_EN
  typedef enum logic {OPEN, LOCKED} state_t;
  state_t           state, state_nxt;
  logic [SEL_W-1:0] lock_ch, lock_ch_nxt;

  always_comb begin
    win = rr_win;
    any = rr_any;
    if (state == LOCKED) begin
      win = lock_ch;
      any = bus.in_valid[lock_ch];
    end
  end

  // Pointer only moves when a burst (or single-beat burst) completes.
  assign adv = bus.in_last[win];

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    if (state == OPEN) begin
      if (accept && !bus.in_last[win]) begin
        state_nxt   = LOCKED;
        lock_ch_nxt = win;
      end
    end else begin
      if (accept && bus.in_last[win]) state_nxt = OPEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OPEN;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end
`else
  assign win = rr_win;
  assign any = rr_any;
  assign adv = 1'b1;
`endif

  assign can_load = !bus.out_valid || bus.out_ready;
  // rst_n gating keeps producers from seeing a grant while the register is held in reset.
  assign accept   = rst_n && can_load && any;
  assign nxt_ptr  = (win == SEL_W'(NUM_IN - 1)) ? '0 : win + 1'b1;

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      bus.in_ready[i] = accept && (win == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      ptr           <= '0;
    end else if (can_load) begin
      bus.out_valid <= any;
      if (any) begin
        bus.out_data <= chan[win];
        bus.out_sel  <= win;
        if (adv) ptr <= nxt_ptr;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: NUM_IN=4 scoreboard-checked main instance plus a NUM_IN=3 wrap instance.
module tb_rr_mux;
  logic clk;
  logic rst_n;
  int   passes = 0;
  int   total  = 0;

  rr_mux_if #(.n(16), .NUM_IN(4)) bus ();
  rr_mux_if #(.n(8),  .NUM_IN(3)) bus3 ();

  rr_mux #(.n(16), .NUM_IN(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  rr_mux #(.n(8),  .NUM_IN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct packed {
    logic [15:0] dat;
    logic [1:0]  sel;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] d [4];
  logic [1:0]  m_ptr;
  logic        m_valid;
  logic [15:0] m_data;
  logic [1:0]  m_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_data();
    bus.in_data = {d[3], d[2], d[1], d[0]};
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    bus3.in_valid = 3'b000;
    @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data),  0);
    chk("rst_out_sel",   32'(bus.out_sel),   0);
    rst_n        = 1'b1;
    bus.in_valid = 4'h0;
    m_ptr   = 2'd0;
    m_valid = 1'b0;
    m_data  = 16'h0;
    m_sel   = 2'd0;
    sb.delete();
  endtask

  // One clock of stimulus; model predicts grant, scoreboard carries the beat to the output.
  task automatic step(input logic [3:0] v, input logic ordy, input int esel);
    logic       can_load;
    logic       found;
    logic       pushed;
    logic [1:0] idx;
    logic [1:0] w;
    logic [3:0] er;
    exp_t       e;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    #1;
    can_load = !m_valid || ordy;
    found    = 1'b0;
    w        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = m_ptr + 2'(k);
      if (!found && v[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    er     = 4'b0000;
    pushed = 1'b0;
    if (can_load && found) begin
      er[w] = 1'b1;
      sb.push_back({d[w], w});
      m_ptr   = w + 2'd1;
      m_valid = 1'b1;
      pushed  = 1'b1;
    end else if (can_load) begin
      m_valid = 1'b0;
    end
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (pushed) begin
      e      = sb.pop_front();
      m_data = e.dat;
      m_sel  = e.sel;
    end
    chk("out_data", 32'(bus.out_data), 32'(m_data));
    chk("out_sel",  32'(bus.out_sel),  32'(m_sel));
    if (esel >= 0) chk("out_sel_seq", 32'(bus.out_sel), 32'(esel));
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 4'h0;
    bus.out_ready  = 1'b1;
    bus3.in_valid  = 3'b000;
    bus3.out_ready = 1'b1;
    bus3.in_data   = {8'h33, 8'h22, 8'h11};
`ifdef RR_MUX_ARB_HOLD_EN
    bus.in_last    = 4'hF;
    bus3.in_last   = 3'b111;
`endif
    for (int i = 0; i < 4; i++) d[i] = 16'hA000 + 16'(i);
    set_data();

    do_reset();

    // Round-robin with all channels valid: 0,1,2,3,0,1 with no bubbles
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, i % 4);

    // Sparse: ptr=3 then only ch0 valid, then ptr must be 1
    step(4'b0100, 1'b1, 2);
    step(4'b0001, 1'b1, 0);
    step(4'b1111, 1'b1, 1);

    // Backpressure on a ch2 beat
    d[2] = 16'h1234;
    set_data();
    step(4'b0100, 1'b1, 2);
    chk("bp_first_data", 32'(bus.out_data), 32'h1234);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 2);
      chk("bp_hold_data", 32'(bus.out_data), 32'h1234);
    end
    step(4'b1111, 1'b1, 3);
    chk("bp_release_valid", 32'(bus.out_valid), 1);

    // Drain, idle, then confirm idle cycles left ptr at 0
    step(4'b0000, 1'b1, 3);
    chk("drain_valid", 32'(bus.out_valid), 0);
    chk("drain_data",  32'(bus.out_data),  32'hA003);
    step(4'b0000, 1'b1, 3);
    step(4'b1111, 1'b1, 0);
    step(4'b0000, 1'b1, -1);

    // NUM_IN=3: ch2 grant must wrap ptr to 0
    bus3.in_valid = 3'b100;
    #1;
    chk("n3_ready_ch2", 32'(bus3.in_ready), 32'b100);
    @(posedge clk);
    #1;
    chk("n3_sel_ch2",  32'(bus3.out_sel),  2);
    chk("n3_data_ch2", 32'(bus3.out_data), 32'h33);
    bus3.in_valid = 3'b111;
    #1;
    chk("n3_ready_wrap", 32'(bus3.in_ready), 32'b001);
    @(posedge clk);
    #1;
    chk("n3_sel_wrap",  32'(bus3.out_sel),  0);
    chk("n3_data_wrap", 32'(bus3.out_data), 32'h11);
    bus3.in_valid = 3'b000;

    // Asynchronous reset while a beat is held
    step(4'b0001, 1'b0, 0);
    chk("pre_async_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 0);
    do_reset();

`ifdef RR_MUX_ARB_HOLD_EN
    d[2] = 16'hA002;
    set_data();
    step(4'b0001, 1'b1, 0);
    begin
      int         seq [5];
      logic [3:0] lst [5];
      seq = '{1, 1, 1, 3, 0};
      lst = '{4'b1101, 4'b1101, 4'b1111, 4'b1111, 4'b1111};
      for (int k = 0; k < 5; k++) begin
        bus.in_last  = lst[k];
        bus.in_valid = 4'b1011;
        #1;
        if (k < 3) chk("hold_ready", 32'(bus.in_ready), 32'b0010);
        @(posedge clk);
        #1;
        chk("hold_sel", 32'(bus.out_sel), 32'(seq[k]));
      end
    end
    bus.in_valid = 4'h0;
    bus.in_last  = 4'hF;
`endif

    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
